// File: rtl/scoreboard_reg_file.sv
// rtl/scoreboard_reg_file.sv - multi-ported register file with pending scoreboard and write-to-read bypass
// Optional build macro REGFILE_ZERO_REG_EN: register 0 is hardwired to zero.
module scoreboard_reg_file #(
    parameter  int N_REGS        = 32,
    parameter  int DATA_WIDTH    = 32,
    parameter  int N_READ_PORTS  = 3,
    parameter  int N_WRITE_PORTS = 2,
    parameter  int N_RSV_PORTS   = 1,
    localparam int ADDR_WIDTH    = $clog2(N_REGS),
    localparam int CNT_WIDTH     = $clog2(N_REGS + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [N_WRITE_PORTS-1:0]              we,
    input  logic [N_WRITE_PORTS*ADDR_WIDTH-1:0]   wAddrs,
    input  logic [N_WRITE_PORTS*DATA_WIDTH-1:0]   wPorts,
    input  logic [N_READ_PORTS-1:0]               re,
    input  logic [N_READ_PORTS*ADDR_WIDTH-1:0]    rAddrs,
    output logic [N_READ_PORTS*DATA_WIDTH-1:0]    rPorts,
    output logic [N_READ_PORTS-1:0]               rValid,
    input  logic [N_RSV_PORTS-1:0]                rsv,
    input  logic [N_RSV_PORTS*ADDR_WIDTH-1:0]     rsvAddrs,
    output logic [N_RSV_PORTS-1:0]                rsvAck,
    output logic [CNT_WIDTH-1:0]                  nPending
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_WIDTH-1:0]   regs_q   [N_REGS];
    logic [DATA_WIDTH-1:0]   regs_d   [N_REGS];
    logic [N_REGS-1:0]       pending_q, pending_d, pending_clr, pending_set, pending_mid;
    logic [CNT_WIDTH-1:0]    n_pending_q, n_pending_d;
    logic [DATA_WIDTH-1:0]   rdata_q  [N_READ_PORTS];
    logic [DATA_WIDTH-1:0]   rdata_d  [N_READ_PORTS];
    logic [N_READ_PORTS-1:0] rvalid_q, rvalid_d;
    logic [N_RSV_PORTS-1:0]  grant;

    logic [ADDR_WIDTH-1:0]    w_addr   [N_WRITE_PORTS];
    logic [DATA_WIDTH-1:0]    w_data   [N_WRITE_PORTS];
    logic [N_WRITE_PORTS-1:0] w_en;
    logic [ADDR_WIDTH-1:0]    r_addr   [N_READ_PORTS];
    logic [ADDR_WIDTH-1:0]    rsv_addr [N_RSV_PORTS];

    for (genvar i = 0; i < N_WRITE_PORTS; i++) begin : g_wr
        assign w_addr[i] = wAddrs[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data[i] = wPorts[i*DATA_WIDTH +: DATA_WIDTH];
        // Writes to a hardwired zero register vanish entirely, bypass included.
        assign w_en[i]   = en & we[i] & ~(ZERO_REG & (w_addr[i] == '0));
    end
    for (genvar j = 0; j < N_READ_PORTS; j++) begin : g_rd
        assign r_addr[j] = rAddrs[j*ADDR_WIDTH +: ADDR_WIDTH];
        assign rPorts[j*DATA_WIDTH +: DATA_WIDTH] = rdata_q[j];
    end
    for (genvar k = 0; k < N_RSV_PORTS; k++) begin : g_rsv
        assign rsv_addr[k] = rsvAddrs[k*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Higher write port index is applied last and therefore wins.
    always_comb begin
        regs_d      = regs_q;
        pending_clr = '0;
        for (int i = 0; i < N_WRITE_PORTS; i++) begin
            if (w_en[i]) begin
                regs_d[w_addr[i]]      = w_data[i];
                pending_clr[w_addr[i]] = 1'b1;
            end
        end
    end

    // A reservation port loses to any lower-index port granted the same address.
    always_comb begin
        grant       = '0;
        pending_set = '0;
        for (int k = 0; k < N_RSV_PORTS; k++) begin
            grant[k] = rst & en & rsv[k] & ~pending_q[rsv_addr[k]];
            for (int m = 0; m < k; m++) begin
                if (grant[m] && (rsv_addr[m] == rsv_addr[k])) grant[k] = 1'b0;
            end
            if (grant[k] && !(ZERO_REG && (rsv_addr[k] == '0))) pending_set[rsv_addr[k]] = 1'b1;
        end
    end

    assign pending_mid = pending_q & ~pending_clr;
    assign pending_d   = pending_mid | pending_set;
    assign rsvAck      = grant;

    always_comb begin
        n_pending_d = '0;
        for (int r = 0; r < N_REGS; r++) n_pending_d = n_pending_d + CNT_WIDTH'(pending_d[r]);
    end

    // Read validity sees write-clears but not same-edge reservations.
    always_comb begin
        for (int j = 0; j < N_READ_PORTS; j++) begin
            rdata_d[j]  = rdata_q[j];
            rvalid_d[j] = rvalid_q[j];
            if (en && re[j]) begin
                rdata_d[j]  = regs_d[r_addr[j]];
                rvalid_d[j] = ~pending_mid[r_addr[j]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < N_REGS; r++) regs_q[r] <= '0;
            for (int j = 0; j < N_READ_PORTS; j++) rdata_q[j] <= '0;
            pending_q   <= '0;
            rvalid_q    <= '0;
            n_pending_q <= '0;
        end else if (en) begin
            regs_q      <= regs_d;
            rdata_q     <= rdata_d;
            pending_q   <= pending_d;
            rvalid_q    <= rvalid_d;
            n_pending_q <= n_pending_d;
        end
    end

    assign rValid   = rvalid_q;
    assign nPending = n_pending_q;

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// tb/tb_scoreboard_reg_file.sv - directed self-checking bench for scoreboard_reg_file
module tb_scoreboard_reg_file;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   we;
    logic [9:0]   wAddrs;
    logic [63:0]  wPorts;
    logic [2:0]   re;
    logic [14:0]  rAddrs;
    logic [95:0]  rPorts;
    logic [2:0]   rValid;
    logic [0:0]   rsv;
    logic [4:0]   rsvAddrs;
    logic [0:0]   rsvAck;
    logic [5:0]   nPending;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [31:0] EXP_R0 = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_R0 = 32'hFFFF_FFFF;
`endif

    scoreboard_reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .we       (we),
        .wAddrs   (wAddrs),
        .wPorts   (wPorts),
        .re       (re),
        .rAddrs   (rAddrs),
        .rPorts   (rPorts),
        .rValid   (rValid),
        .rsv      (rsv),
        .rsvAddrs (rsvAddrs),
        .rsvAck   (rsvAck),
        .nPending (nPending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0; wAddrs = '0; wPorts = '0;
        re = '0; rAddrs = '0; rsv = '0; rsvAddrs = '0;
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        we = 2'b11; wAddrs = 10'($urandom); wPorts = {$urandom, $urandom};
        re = 3'b111; rAddrs = 15'($urandom); rsv = 1'b1; rsvAddrs = 5'($urandom);
        tick();
        tick();
        check("reset_rports", rPorts, 96'h0);
        check("reset_rvalid", rValid, 3'b000);
        check("reset_npending", nPending, 6'd0);
        check("reset_rsvack", rsvAck, 1'b0);
        idle();
        rst = 1'b1;
        tick();

        we = 2'b11; wAddrs = {5'd1, 5'd0}; wPorts = {32'hCCCC_CCCC, 32'hFFFF_FFFF};
        tick();
        idle();
        re = 3'b111; rAddrs = {5'd2, 5'd1, 5'd0};
        tick();
        check("rd_reg0", rPorts[31:0], EXP_R0);
        check("rd_reg1", rPorts[63:32], 32'hCCCC_CCCC);
        check("rd_reg2", rPorts[95:64], 32'h0);
        check("rd_valid", rValid, 3'b111);

        idle();
        we = 2'b11; wAddrs = {5'd5, 5'd5}; wPorts = {32'h2222_2222, 32'h1111_1111};
        re = 3'b001; rAddrs = {5'd0, 5'd0, 5'd5};
        tick();
        check("bypass_conflict", rPorts[31:0], 32'h2222_2222);
        check("bypass_valid", rValid[0], 1'b1);
        check("hold_port1", rPorts[63:32], 32'hCCCC_CCCC);
        we = '0;
        tick();
        check("reread_reg5", rPorts[31:0], 32'h2222_2222);

        idle();
        rsv = 1'b1; rsvAddrs = 5'd7;
        #1;
        check("rsv7_ack", rsvAck, 1'b1);
        tick();
        check("rsv7_npending", nPending, 6'd1);
        check("rsv7_again_ack", rsvAck, 1'b0);
        tick();
        check("rsv7_again_npending", nPending, 6'd1);
        idle();
        re = 3'b001; rAddrs = {5'd0, 5'd0, 5'd7};
        tick();
        check("rd7_pending_valid", rValid[0], 1'b0);
        idle();
        we = 2'b01; wAddrs = {5'd0, 5'd7}; wPorts = {32'h0, 32'hABCD_0000};
        tick();
        check("wr7_npending", nPending, 6'd0);
        idle();
        re = 3'b001; rAddrs = {5'd0, 5'd0, 5'd7};
        tick();
        check("rd7_data", rPorts[31:0], 32'hABCD_0000);
        check("rd7_valid", rValid[0], 1'b1);

        idle();
        we = 2'b01; wAddrs = {5'd0, 5'd3}; wPorts = {32'h0, 32'h3333_3333};
        rsv = 1'b1; rsvAddrs = 5'd3;
        re = 3'b001; rAddrs = {5'd0, 5'd0, 5'd3};
        #1;
        check("sim_rsvack", rsvAck, 1'b1);
        tick();
        check("sim_rd_data", rPorts[31:0], 32'h3333_3333);
        check("sim_rd_valid", rValid[0], 1'b1);
        check("sim_npending", nPending, 6'd1);
        we = '0; rsv = '0;
        tick();
        check("sim_reread_valid", rValid[0], 1'b0);
        check("sim_reread_data", rPorts[31:0], 32'h3333_3333);

        en = 1'b0;
        we = 2'b11; wAddrs = {5'd10, 5'd9}; wPorts = {32'hDEAD_BEEF, 32'h1234_5678};
        rsv = 1'b1; rsvAddrs = 5'd12;
        re = 3'b111; rAddrs = {5'd7, 5'd5, 5'd3};
        for (int c = 0; c < 3; c++) begin
            #1;
            check("en0_rsvack", rsvAck, 1'b0);
            tick();
        end
        check("en0_rports", rPorts, {32'h0, 32'hCCCC_CCCC, 32'h3333_3333});
        check("en0_rvalid", rValid, 3'b110);
        check("en0_npending", nPending, 6'd1);
        en = 1'b1;
        idle();
        re = 3'b111; rAddrs = {5'd12, 5'd10, 5'd9};
        tick();
        check("en0_nowrite", rPorts, 96'h0);
        check("en0_nowrite_valid", rValid, 3'b111);
        check("en0_norsv_npending", nPending, 6'd1);

        rst = 1'b0;
        #1;
        check("midrst_npending", nPending, 6'd0);
        check("midrst_rvalid", rValid, 3'b000);
        tick();
        rst = 1'b1;
        re = 3'b001; rAddrs = {5'd0, 5'd0, 5'd3};
        tick();
        check("midrst_reg3_data", rPorts[31:0], 32'h0);
        check("midrst_reg3_valid", rValid[0], 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/scoreboard_reg_file.md
# scoreboard_reg_file

Parametrised multi-ported register file with a per-register pending scoreboard and write-to-read bypass; successor to the basic multi-ported register file. Sits between issue and writeback. Producers reserve destination registers, writers clear them. Every read returns data plus a valid flag telling the consumer whether the value is final.

## Interface
- N_REGS, 32, number of registers (≥2)
- DATA_WIDTH, 32, register width
- N_READ_PORTS, 3, read ports
- N_WRITE_PORTS, 2, write ports
- N_RSV_PORTS, 1, reservation ports
- ADDR_WIDTH, $clog2(N_REGS), derived, not overridden
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- en  input  1  global enable; 0 freezes all state and outputs
- we  input  [N_WRITE_PORTS]x1  write enables
- wAddrs  input  [N_WRITE_PORTS]xADDR_WIDTH  write addresses
- wPorts  input  [N_WRITE_PORTS]xDATA_WIDTH  write data
- re  input  [N_READ_PORTS]x1  read enables
- rAddrs  input  [N_READ_PORTS]xADDR_WIDTH  read addresses
- rPorts  output  [N_READ_PORTS]xDATA_WIDTH  registered read data
- rValid  output  [N_READ_PORTS]x1  registered; 1 = rPorts holds a non-pending value
- rsv  input  [N_RSV_PORTS]x1  reservation requests
- rsvAddrs  input  [N_RSV_PORTS]xADDR_WIDTH  reservation addresses
- rsvAck  output  [N_RSV_PORTS]x1  combinational grant
- nPending  output  $clog2(N_REGS+1)  registered count of pending registers

## Operation
- Reset (rst=0, async): all registers, pending bits, rPorts, rValid, nPending cleared to 0; rsvAck forced 0.
- Write: at rising edge with en=1, each we[i] writes wPorts[i] to wAddrs[i] and clears that register's pending bit.
- Write conflict: several we to one address in one cycle → highest port index wins. Pending is cleared once.
- Reservation: rsvAck[k] = en & rsv[k] & !pending[rsvAddrs[k]] & no lower-index rsv port granted the same address this cycle. A granted reservation sets pending at the edge.
- Reservation vs write, same register, same edge: reservation wins. Data is written and the register ends pending. This is the new producer's tag.
- Read: at edge with en=1 and re[j]=1:
  - rPorts[j] gets the register value. If a same-cycle write targets rAddrs[j], it gets the winning write data instead (bypass).
  - rValid[j] gets !pending after this edge's write-clears, evaluated before this edge's reservations. A same-cycle reserve therefore does not invalidate a same-cycle read.
- re[j]=0: rPorts[j] and rValid[j] hold.
- nPending: updated each enabled edge to the popcount of the next pending vector. Range 0..N_REGS, no wrap.
- en=0: no writes, reservations or read updates. rsvAck=0.

## Timing
- Read latency 1 cycle: address at edge t, data/valid visible after edge t.
- Write-to-read latency 0 via bypass. A read issued at the same edge as a write returns the new data.
- Reserve-to-blocked: a register reserved at edge t yields rValid=0 for reads issued at edge t+1 onward, until a write clears it.
- rsvAck is combinational from rsv, rsvAddrs and pending. No input-to-registered-output combinational path.
- Reset deassertion mid-operation: first enabled edge after release behaves as from a clean state.

## Configuration
- REGFILE_ZERO_REG_EN defined: register 0 is hardwired zero.
  - Writes to 0 are ignored; reads of 0 return 0 with rValid=1.
  - rsv to 0 is acked but never sets pending and never counts in nPending.
- Undefined: register 0 is an ordinary register.

## Test plan
- Reset: hold rst=0 two cycles with random inputs → rPorts all 0, rValid 0, nPending 0, rsvAck 0.
- Write/read: write reg0=FFFFFFFF, reg1=CCCCCCCC; read 0,1,2 next cycle → FFFFFFFF, CCCCCCCC, 0, rValid 1,1,1. With REGFILE_ZERO_REG_EN, read 0 → 0.
- Bypass and conflict: at one edge, we[0] and we[1] both to reg5 (11111111, 22222222) while reading 5 → rPorts=22222222 the same cycle; re-read → 22222222.
- Scoreboard: rsv reg7 (ack=1, nPending=1).
  - Second rsv reg7 → ack=0.
  - Read 7 → rValid=0.
  - Write 7=ABCD0000 → nPending=0; read → ABCD0000, rValid=1.
- Simultaneous: write reg3 and rsv reg3 at same edge with read 3 → rValid=1 that read, rValid=0 on the next read, nPending=1.
- en=0 for 3 cycles with we/rsv/re active → no state or output change.
